// File: rtl/key_search_controller.sv
// Brute-force RC4 key search controller.
// Walks the key from KEY_FIRST to KEY_LAST. For each key it launches the decode
// sequencer, waits for it, then launches the plaintext checker. The search stops
// on the first passing key (found) or after KEY_LAST fails (exhausted).
//
// Ports:
//   clk            - clock, rising edge
//   reset          - synchronous, active-high reset
//   start          - level-sampled request to begin a search (ignored while busy)
//   abort          - cancels a search in progress
//   decode_finish  - pulse: decode sequence for the current key has completed
//   check_finish   - pulse: plaintext checker has completed
//   check_pass     - checker verdict, valid together with check_finish
//   key            - key under test
//   decode_start   - pulse launching the decode sequence
//   check_start    - pulse launching the plaintext checker
//   busy           - search in progress
//   found          - last search ended with a passing key (held in key)
//   exhausted      - last search tried KEY_LAST without a pass
//   keys_tried     - number of check verdicts received in the current/last search
module key_search_controller #(
  parameter int unsigned          KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 decode_finish,
  input  logic                 check_finish,
  input  logic                 check_pass,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 decode_start,
  output logic                 check_start,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH:0]   keys_tried
);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StStartDec,
    StWaitDec,
    StStartChk,
    StWaitChk,
    StNextKey,
    StFound,
    StExhaust
  } state_e;

  localparam logic [KEY_WIDTH-1:0] KeyOne   = {{(KEY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH:0]   TriedOne = {{KEY_WIDTH{1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic   busy_now;

  function automatic logic is_busy(input state_e s);
    return s inside {StLoad, StStartDec, StWaitDec, StStartChk, StWaitChk, StNextKey};
  endfunction

  assign busy_now = is_busy(state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start && !abort) state_d = StLoad;
      StLoad:     state_d = StStartDec;
      StStartDec: state_d = StWaitDec;
      StWaitDec:  if (decode_finish) state_d = StStartChk;
      StStartChk: state_d = StWaitChk;
      StWaitChk: begin
        if (check_finish) begin
          if (check_pass)           state_d = StFound;
          else if (key == KEY_LAST) state_d = StExhaust;
          else                      state_d = StNextKey;
        end
      end
      StNextKey:  state_d = StStartDec;
      StFound:    if (start) state_d = StLoad;
      StExhaust:  if (start) state_d = StLoad;
      default:    state_d = StIdle;
    endcase
    // Abort beats every other transition, including a same-cycle verdict.
    if (busy_now && abort) state_d = StIdle;
  end

  // Outputs are registered and decoded from the next state so each pulse lines
  // up exactly with the cycle spent in its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      key          <= KEY_FIRST;
      keys_tried   <= '0;
      decode_start <= 1'b0;
      check_start  <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
    end else begin
      state_q      <= state_d;
      decode_start <= (state_d == StStartDec);
      check_start  <= (state_d == StStartChk);
      busy         <= is_busy(state_d);
      found        <= (state_d == StFound);
      exhausted    <= (state_d == StExhaust);
      if (!(busy_now && abort)) begin
        if (state_q == StLoad) begin
          key        <= KEY_FIRST;
          keys_tried <= '0;
        end
        if (state_q == StWaitChk && check_finish) begin
          keys_tried <= keys_tried + TriedOne;
        end
        // NEXT_KEY is only reached when key != KEY_LAST, so this never wraps.
        if (state_q == StNextKey) begin
          key <= key + KeyOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_search_controller.sv
// Scoreboard bench for key_search_controller. Three instances cover the
// different key ranges: A = 0..3, B = 14..15 (top of a 4-bit range), C = 0..15.
// Only one instance searches at a time; the handshake inputs are shared.
module tb_key_search_controller;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, abort, decode_finish, check_finish, check_pass;
  logic [2:0] start;

  logic         decode_start [3];
  logic         check_start  [3];
  logic         busy         [3];
  logic         found        [3];
  logic         exhausted    [3];
  logic [W-1:0] key          [3];
  logic [W:0]   keys_tried   [3];

  key_search_controller #(.KEY_WIDTH(W), .KEY_FIRST(4'd0), .KEY_LAST(4'd3)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort),
    .decode_finish(decode_finish), .check_finish(check_finish), .check_pass(check_pass),
    .key(key[0]), .decode_start(decode_start[0]), .check_start(check_start[0]),
    .busy(busy[0]), .found(found[0]), .exhausted(exhausted[0]), .keys_tried(keys_tried[0])
  );

  key_search_controller #(.KEY_WIDTH(W), .KEY_FIRST(4'd14), .KEY_LAST(4'd15)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort),
    .decode_finish(decode_finish), .check_finish(check_finish), .check_pass(check_pass),
    .key(key[1]), .decode_start(decode_start[1]), .check_start(check_start[1]),
    .busy(busy[1]), .found(found[1]), .exhausted(exhausted[1]), .keys_tried(keys_tried[1])
  );

  key_search_controller #(.KEY_WIDTH(W), .KEY_FIRST(4'd0), .KEY_LAST(4'd15)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort),
    .decode_finish(decode_finish), .check_finish(check_finish), .check_pass(check_pass),
    .key(key[2]), .decode_start(decode_start[2]), .check_start(check_start[2]),
    .busy(busy[2]), .found(found[2]), .exhausted(exhausted[2]), .keys_tried(keys_tried[2])
  );

  typedef struct {
    int           id;
    logic [W-1:0] key;
  } pulse_t;

  typedef struct {
    int           id;
    logic         found;
    logic         exhausted;
    logic [W-1:0] key;
    logic [W:0]   tried;
  } result_t;

  pulse_t  dec_q[$];
  pulse_t  chk_q[$];
  result_t res_q[$];
  pulse_t  mp;
  result_t mr;
  logic    busy_prev [3] = '{1'b0, 1'b0, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input int id, input logic [W-1:0] k);
    n_tests++;
    n_fail++;
    $display("FAIL %s dut%0d: got pulse with key %0d, required none", name, id, k);
  endfunction

  // Monitor: pops the scoreboard whenever a DUT shows a pulse or ends a search.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (decode_start[i] === 1'b1 || check_start[i] === 1'b1) begin
        check($sformatf("start_exclusive dut%0d", i),
              {31'd0, decode_start[i] & check_start[i]}, 0);
      end
      if (decode_start[i] === 1'b1) begin
        if (dec_q.size() == 0) unexpected("decode_start", i, key[i]);
        else begin
          mp = dec_q.pop_front();
          check($sformatf("decode_start_dut dut%0d", i), i, mp.id);
          check($sformatf("decode_start_key dut%0d", i), {28'd0, key[i]}, {28'd0, mp.key});
        end
      end
      if (check_start[i] === 1'b1) begin
        if (chk_q.size() == 0) unexpected("check_start", i, key[i]);
        else begin
          mp = chk_q.pop_front();
          check($sformatf("check_start_dut dut%0d", i), i, mp.id);
          check($sformatf("check_start_key dut%0d", i), {28'd0, key[i]}, {28'd0, mp.key});
        end
      end
      if (busy_prev[i] === 1'b1 && busy[i] === 1'b0) begin
        if (res_q.size() == 0) unexpected("search_end", i, key[i]);
        else begin
          mr = res_q.pop_front();
          check($sformatf("end_dut dut%0d", i), i, mr.id);
          check($sformatf("end_found dut%0d", i), {31'd0, found[i]}, {31'd0, mr.found});
          check($sformatf("end_exhausted dut%0d", i), {31'd0, exhausted[i]},
                {31'd0, mr.exhausted});
          check($sformatf("end_key dut%0d", i), {28'd0, key[i]}, {28'd0, mr.key});
          check($sformatf("end_keys_tried dut%0d", i), {27'd0, keys_tried[i]},
                {27'd0, mr.tried});
        end
      end
      busy_prev[i] <= busy[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit seen(input int id, input int which);
    case (which)
      0:       return decode_start[id] === 1'b1;
      1:       return check_start[id] === 1'b1;
      default: return busy[id] === 1'b0;
    endcase
  endfunction

  // which: 0 = decode_start, 1 = check_start, 2 = busy low.
  task automatic wait_for(input int id, input int which, input string name);
    int n = 0;
    while (!seen(id, which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!seen(id, which)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout dut%0d: got no event in %0d cycles, required one", name, id, n);
    end
  endtask

  task automatic push_key(input int id, input int k, input bit with_check);
    pulse_t p;
    p.id  = id;
    p.key = W'(k);
    dec_q.push_back(p);
    if (with_check) chk_q.push_back(p);
  endtask

  task automatic push_res(input int id, input bit f, input bit e, input int k, input int t);
    result_t r;
    r.id = id; r.found = f; r.exhausted = e; r.key = W'(k); r.tried = (W + 1)'(t);
    res_q.push_back(r);
  endtask

  task automatic pulse_start(input int id);
    start[id] = 1'b1;
    tick(1);
    start[id] = 1'b0;
  endtask

  // Serves one key: decode finishes dec_delay cycles after decode_start, then the
  // checker answers. Optionally holds start high mid-search, aborts with the
  // verdict, and checks that the next key's decode_start follows 2 cycles later.
  task automatic run_key(input int id, input int dec_delay, input bit pass,
                         input bit abort_now, input bit poke_start, input bit next_key);
    wait_for(id, 0, "decode_start");
    if (poke_start) start[id] = 1'b1;
    tick(dec_delay);
    start[id]     = 1'b0;
    decode_finish = 1'b1;
    tick(1);
    decode_finish = 1'b0;
    check($sformatf("check_start_latency dut%0d", id), {31'd0, check_start[id]}, 1);
    tick(2);
    check_finish = 1'b1;
    check_pass   = pass;
    abort        = abort_now;
    tick(1);
    check_finish = 1'b0;
    check_pass   = 1'b0;
    abort        = 1'b0;
    if (next_key) begin
      tick(1);
      check($sformatf("next_decode_latency dut%0d", id), {31'd0, decode_start[id]}, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; abort = 1'b0; decode_finish = 1'b0; check_finish = 1'b0;
    check_pass = 1'b0; start = '0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_key dut%0d", i), {28'd0, key[i]}, (i == 1) ? 14 : 0);
      check($sformatf("reset_keys_tried dut%0d", i), {27'd0, keys_tried[i]}, 0);
      check($sformatf("reset_flags dut%0d", i),
            {27'd0, decode_start[i], check_start[i], busy[i], found[i], exhausted[i]}, 0);
    end
    reset = 1'b0;
    tick(2);

    // A: pass on key 2, decode takes 7 cycles on the first key, start poked while busy.
    for (int k = 0; k < 3; k++) push_key(0, k, 1'b1);
    push_res(0, 1'b1, 1'b0, 2, 3);
    pulse_start(0);
    run_key(0, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    run_key(0, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_key(0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_for(0, 2, "search_end");
    tick(2);

    // A: restart from FOUND, checker never passes.
    for (int k = 0; k < 4; k++) push_key(0, k, 1'b1);
    push_res(0, 1'b0, 1'b1, 3, 4);
    pulse_start(0);
    for (int k = 0; k < 4; k++) run_key(0, 2, 1'b0, 1'b0, 1'b0, k < 3);
    wait_for(0, 2, "search_end");
    tick(2);

    // B: top of the key space, must stop at 15 without wrapping to 0.
    push_key(1, 14, 1'b1);
    push_key(1, 15, 1'b1);
    push_res(1, 1'b0, 1'b1, 15, 2);
    pulse_start(1);
    run_key(1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    run_key(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_for(1, 2, "search_end");
    tick(4);

    // C: abort together with a passing verdict on key 1.
    push_key(2, 0, 1'b1);
    push_key(2, 1, 1'b1);
    push_res(2, 1'b0, 1'b0, 1, 1);
    pulse_start(2);
    run_key(2, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_key(2, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_for(2, 2, "search_end");
    tick(2);

    // C: reset while waiting for decode of key 5; the late finish must be ignored.
    for (int k = 0; k < 6; k++) push_key(2, k, k < 5);
    push_res(2, 1'b0, 1'b0, 0, 0);
    pulse_start(2);
    for (int k = 0; k < 5; k++) run_key(2, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_for(2, 0, "decode_start");
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    decode_finish = 1'b1;
    tick(1);
    decode_finish = 1'b0;
    tick(4);
    check("after_reset_busy", {31'd0, busy[2]}, 0);
    check("after_reset_key", {28'd0, key[2]}, 0);

    // C: start and abort together in IDLE, abort wins.
    start[2] = 1'b1;
    abort    = 1'b1;
    tick(1);
    start[2] = 1'b0;
    abort    = 1'b0;
    tick(3);
    check("start_abort_idle_busy", {31'd0, busy[2]}, 0);

    // C: a fresh start begins again at KEY_FIRST.
    push_key(2, 0, 1'b1);
    push_res(2, 1'b1, 1'b0, 0, 1);
    pulse_start(2);
    run_key(2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_for(2, 2, "search_end");
    tick(3);

    check("decode_queue_empty", dec_q.size(), 0);
    check("check_queue_empty", chk_q.size(), 0);
    check("result_queue_empty", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_search_controller.md
KEY_SEARCH_CONTROLLER -- requirements
Module: key_search_controller

Interface
REQ-001 Parameter KEY_WIDTH, 24, width of the RC4 secret key and the key counter; SHALL be 2..32.
REQ-002 Parameter KEY_FIRST, 24'h000000, first key tried after start.
REQ-003 Parameter KEY_LAST, 24'h3FFFFF, last key tried; SHALL satisfy KEY_LAST >= KEY_FIRST.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begins a search from KEY_FIRST; level-sampled.
REQ-007 abort  input  1  cancels a search in progress.
REQ-008 decode_finish  input  1  one-cycle pulse: the init/shuffle/decode sequence for the current key has completed.
REQ-009 check_finish  input  1  one-cycle pulse: the plaintext checker has completed.
REQ-010 check_pass  input  1  checker verdict; valid only in the cycle check_finish=1.
REQ-011 key  output  KEY_WIDTH  key presented to the decode sequencer and checker.
REQ-012 decode_start  output  1  one-cycle pulse launching the decode sequence for key.
REQ-013 check_start  output  1  one-cycle pulse launching the plaintext checker.
REQ-014 busy  output  1  high while a search is in progress.
REQ-015 found  output  1  high while the last search ended with key passing the check.
REQ-016 exhausted  output  1  high while the last search tried KEY_LAST without a pass.
REQ-017 keys_tried  output  KEY_WIDTH+1  count of check verdicts received in the current or last search.

Function
REQ-018 States SHALL be IDLE, LOAD, START_DEC, WAIT_DEC, START_CHK, WAIT_CHK, NEXT_KEY, FOUND, EXHAUST.
REQ-019 IDLE: start=1 -> LOAD; otherwise remain.
REQ-020 LOAD: key<=KEY_FIRST, keys_tried<=0, found<=0, exhausted<=0; -> START_DEC.
REQ-021 START_DEC: decode_start=1 for exactly this cycle; -> WAIT_DEC.
REQ-022 WAIT_DEC: decode_finish=1 -> START_CHK; otherwise remain, indefinitely (no timeout).
REQ-023 START_CHK: check_start=1 for exactly this cycle; -> WAIT_CHK.
REQ-024 WAIT_CHK on check_finish=1: keys_tried increments by 1; check_pass=1 -> FOUND; else key==KEY_LAST -> EXHAUST; else -> NEXT_KEY.
REQ-025 NEXT_KEY: key<=key+1; -> START_DEC; a new key therefore starts 2 cycles after the failing check_finish.
REQ-026 FOUND: found=1, key held at the passing key; start=1 -> LOAD (restart), else remain.
REQ-027 EXHAUST: exhausted=1, key held at KEY_LAST; start=1 -> LOAD, else remain.
REQ-028 busy SHALL be 1 in LOAD, START_DEC, WAIT_DEC, START_CHK, WAIT_CHK, NEXT_KEY, and 0 otherwise.
REQ-029 decode_start and check_start SHALL never be asserted together, and neither SHALL be asserted outside START_DEC/START_CHK.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 abort=1 while busy=1 -> IDLE next cycle, overriding every other transition including a simultaneous check_finish; key and keys_tried held; found=0, exhausted=0.
REQ-032 abort in IDLE, FOUND or EXHAUST SHALL have no effect; start and abort asserted together in IDLE: abort wins, state stays IDLE.
REQ-033 decode_finish outside WAIT_DEC and check_finish outside WAIT_CHK SHALL be ignored and SHALL NOT change keys_tried.
REQ-034 The key increment SHALL never wrap; KEY_LAST = 2^KEY_WIDTH-1 SHALL terminate in EXHAUST, not wrap to 0.
REQ-035 keys_tried SHALL NOT saturate or wrap for any legal range (its width is KEY_WIDTH+1).
REQ-036 Any undefined state encoding SHALL transition to IDLE on the next cycle.

Reset
REQ-037 reset=1 SHALL, on the next rising edge, force IDLE, key=KEY_FIRST, keys_tried=0, and decode_start, check_start, busy, found, exhausted all 0, regardless of state.
REQ-038 Reset during WAIT_DEC or WAIT_CHK SHALL discard the pending handshake; a finish pulse arriving after reset SHALL be ignored.

Verification
REQ-039 KEY_FIRST=0, KEY_LAST=3; start; checker passes on key 2 -> exactly 3 decode_start pulses (keys 0,1,2), found=1, key=2, keys_tried=3, busy=0.
REQ-040 KEY_FIRST=0, KEY_LAST=3; checker never passes -> 4 decode_start pulses, exhausted=1, key=3, keys_tried=4, found=0.
REQ-041 KEY_WIDTH=4, KEY_FIRST=14, KEY_LAST=15, no pass -> keys 14,15 tried, EXHAUST, key=15, no decode_start with key=0.
REQ-042 abort asserted in the same cycle as check_finish with check_pass=1 on key 1 -> IDLE, found=0, keys_tried unchanged, key=1.
REQ-043 reset pulsed during WAIT_DEC on key 5, then decode_finish -> all outputs at reset values, no check_start; a later start restarts from KEY_FIRST.
REQ-044 Handshake timing: decode_finish arrives 7 cycles after decode_start -> check_start is exactly 1 cycle after decode_finish; a failing check_finish -> next decode_start exactly 2 cycles later with key+1.
